// File: rtl/quad_pkg.sv
// ----------------------------------------------------------------------------
// quad_pkg
// Shared types and helpers for the quadrature decoder:
//   phase_t     - FSM phase states; the Pxx name is the filtered {A,B} value
//   step_t      - classification of an (old, new) phase pair
//   fwd_next    - next {A,B} in the forward Gray sequence 00->01->11->10->00
//   classify    - forward / reverse / illegal / none for an (old, new) pair
//   phase_of    - phase state for a filtered {A,B} value
//   ab_of       - filtered {A,B} value for a phase state
//   res_gate    - per-destination pulse mask for a resolution setting
//   cnt_width   - debounce counter width for a given stable-cycle count
// ----------------------------------------------------------------------------
package quad_pkg;

    typedef enum logic [2:0] {
        ST_INIT = 3'd0,
        ST_P00  = 3'd1,
        ST_P01  = 3'd2,
        ST_P11  = 3'd3,
        ST_P10  = 3'd4
    } phase_t;

    typedef enum logic [1:0] {
        STEP_NONE = 2'd0,
        STEP_FWD  = 2'd1,
        STEP_REV  = 2'd2,
        STEP_ILL  = 2'd3
    } step_t;

    // Pulse masks indexed by the destination {A,B} value.
    localparam logic [3:0] GATE_RES4 = 4'b1111;  // every transition
    localparam logic [3:0] GATE_RES2 = 4'b1001;  // into 00 or 11
    localparam logic [3:0] GATE_RES1 = 4'b0001;  // into 00 only

    function automatic logic [3:0] res_gate(input int res);
        case (res)
            1:       return GATE_RES1;
            2:       return GATE_RES2;
            default: return GATE_RES4;
        endcase
    endfunction

    function automatic int cnt_width(input int cycles);
        return $clog2(cycles + 1);
    endfunction

    // Forward Gray successor: 00->01->11->10->00.
    function automatic logic [1:0] fwd_next(input logic [1:0] ab);
        return {ab[0], ~ab[1]};
    endfunction

    function automatic step_t classify(input logic [1:0] old_ab,
                                       input logic [1:0] new_ab);
        if (old_ab == new_ab) begin
            return STEP_NONE;
        end else if ((old_ab ^ new_ab) == 2'b11) begin
            return STEP_ILL;
        end else if (fwd_next(old_ab) == new_ab) begin
            return STEP_FWD;
        end else begin
            return STEP_REV;
        end
    endfunction

    function automatic phase_t phase_of(input logic [1:0] ab);
        case (ab)
            2'b00:   return ST_P00;
            2'b01:   return ST_P01;
            2'b11:   return ST_P11;
            default: return ST_P10;
        endcase
    endfunction

    function automatic logic [1:0] ab_of(input phase_t ph);
        case (ph)
            ST_P01:  return 2'b01;
            ST_P11:  return 2'b11;
            ST_P10:  return 2'b10;
            default: return 2'b00;
        endcase
    endfunction

endpackage

// File: rtl/quad_filter.sv
// ----------------------------------------------------------------------------
// quad_filter
// One encoder channel: synchronizer chain, debounce counter and valid flag.
// Parameters:
//   SYNC_STAGES     - synchronizer depth (2..3)
//   DEBOUNCE_CYCLES - consecutive cycles a new level must persist (1..255)
// Ports:
//   clk    in  - clock, rising edge
//   reset  in  - synchronous active-high reset
//   din    in  - raw channel, asynchronous to clk
//   level  out - filtered level
//   valid  out - filtered level has been established since reset
// ----------------------------------------------------------------------------
module quad_filter
    import quad_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic level,
    output logic valid
);

    localparam int CNT_W = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [SYNC_STAGES-1:0] sync_q,  sync_d;
    // Travels alongside the synchronizer so that the reset contents of the
    // chain are never mistaken for a real sample of the channel.
    logic [SYNC_STAGES-1:0] prime_q, prime_d;
    logic [CNT_W-1:0]       cnt_q,   cnt_d;
    logic                   level_q, level_d;
    logic                   valid_q, valid_d;

    logic sync_lvl;
    logic primed;

    assign sync_lvl = sync_q[SYNC_STAGES-1];
    assign primed   = prime_q[SYNC_STAGES-1];

    always_comb begin
        sync_d  = {sync_q[SYNC_STAGES-2:0], din};
        prime_d = {prime_q[SYNC_STAGES-2:0], 1'b1};
        cnt_d   = cnt_q;
        level_d = level_q;
        valid_d = valid_q;

        if (!valid_q) begin
            // Acquisition: follow the synchronized level and declare it
            // valid once it has held for DEBOUNCE_CYCLES cycles.
            if (primed) begin
                if (sync_lvl != level_q) begin
                    level_d = sync_lvl;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    valid_d = 1'b1;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
        end else if (sync_lvl != level_q) begin
            // The DEBOUNCE_CYCLES-th consecutive differing sample commits.
            if (cnt_q == CNT_LAST) begin
                level_d = sync_lvl;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + CNT_ONE;
            end
        end else begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q  <= '0;
            prime_q <= '0;
            cnt_q   <= '0;
            level_q <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            prime_q <= prime_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            valid_q <= valid_d;
        end
    end

    assign level = level_q;
    assign valid = valid_q;

endmodule

// File: rtl/quadrature_decoder.sv
// ----------------------------------------------------------------------------
// quadrature_decoder
// Turns two asynchronous quadrature channels into single-cycle increment /
// decrement pulses for a 4-bit up/down counter, with a sticky illegal-jump
// error flag.
// Parameters:
//   SYNC_STAGES     - synchronizer depth per channel (2..3)
//   DEBOUNCE_CYCLES - stable cycles before a filtered level changes (1..255)
//   RES             - counts per encoder cycle (1, 2 or 4)
// Ports:
//   clk         in  - clock, rising edge
//   reset       in  - synchronous active-high reset
//   enc_a       in  - encoder channel A (asynchronous)
//   enc_b       in  - encoder channel B (asynchronous)
//   enable      in  - 0 suppresses pulses and error setting; tracking goes on
//   error_clear in  - clears the sticky error flag on the next edge
//   increment   out - one-cycle forward pulse
//   decrement   out - one-cycle reverse pulse
//   direction   out - last legal step direction, 1 = forward
//   error       out - sticky, set on a two-bit phase jump
// Pipeline: filters -> FSM/step register -> output register. All outputs
// come straight from flops.
// ----------------------------------------------------------------------------
module quadrature_decoder
    import quad_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int RES             = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic enc_a,
    input  logic enc_b,
    input  logic enable,
    input  logic error_clear,
    output logic increment,
    output logic decrement,
    output logic direction,
    output logic error
);

    localparam logic [3:0] GATE_MASK = res_gate(RES);

    logic a_level, a_valid;
    logic b_level, b_valid;
    logic [1:0] filt_ab;

    quad_filter #(
        .SYNC_STAGES     (SYNC_STAGES),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_filter_a (
        .clk   (clk),
        .reset (reset),
        .din   (enc_a),
        .level (a_level),
        .valid (a_valid)
    );

    quad_filter #(
        .SYNC_STAGES     (SYNC_STAGES),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_filter_b (
        .clk   (clk),
        .reset (reset),
        .din   (enc_b),
        .level (b_level),
        .valid (b_valid)
    );

    assign filt_ab = {a_level, b_level};

    // ------------------------------------------------------------------
    // Phase FSM and step register
    // ------------------------------------------------------------------
    phase_t state_q, state_d;
    logic   fwd_q,  fwd_d;
    logic   rev_q,  rev_d;
    logic   ill_q,  ill_d;
    logic   gate_q, gate_d;
    step_t  step_kind;

    always_comb begin
        state_d   = state_q;
        fwd_d     = 1'b0;
        rev_d     = 1'b0;
        ill_d     = 1'b0;
        gate_d    = GATE_MASK[filt_ab];
        step_kind = STEP_NONE;

        case (state_q)
            ST_INIT: begin
                // Initial load only; never a step.
                if (a_valid && b_valid) begin
                    state_d = phase_of(filt_ab);
                end
            end
            default: begin
                step_kind = classify(ab_of(state_q), filt_ab);
                // An illegal jump resyncs to the observed phase as well.
                state_d   = phase_of(filt_ab);
                case (step_kind)
                    STEP_FWD: fwd_d = 1'b1;
                    STEP_REV: rev_d = 1'b1;
                    STEP_ILL: ill_d = 1'b1;
                    default:  ;
                endcase
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_INIT;
            fwd_q   <= 1'b0;
            rev_q   <= 1'b0;
            ill_q   <= 1'b0;
            gate_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            fwd_q   <= fwd_d;
            rev_q   <= rev_d;
            ill_q   <= ill_d;
            gate_q  <= gate_d;
        end
    end

    // ------------------------------------------------------------------
    // Output register stage
    // ------------------------------------------------------------------
    logic increment_q, increment_d;
    logic decrement_q, decrement_d;
    logic direction_q, direction_d;
    logic error_q,     error_d;

    always_comb begin
        increment_d = enable && fwd_q && gate_q;
        decrement_d = enable && rev_q && gate_q;

        // Gated-off and disabled steps still record their direction.
        direction_d = direction_q;
        if (fwd_q) begin
            direction_d = 1'b1;
        end else if (rev_q) begin
            direction_d = 1'b0;
        end

        // A new illegal jump beats a simultaneous clear.
        error_d = error_q;
        if (ill_q && enable) begin
            error_d = 1'b1;
        end else if (error_clear) begin
            error_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            increment_q <= 1'b0;
            decrement_q <= 1'b0;
            direction_q <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            increment_q <= increment_d;
            decrement_q <= decrement_d;
            direction_q <= direction_d;
            error_q     <= error_d;
        end
    end

    assign increment = increment_q;
    assign decrement = decrement_q;
    assign direction = direction_q;
    assign error     = error_q;

endmodule

// File: tb/tb_quadrature_decoder.sv
// ----------------------------------------------------------------------------
// tb_quadrature_decoder
// Two decoders share the stimulus: dut4 with defaults (RES=4) and dut1 with
// RES=1. Each driven channel change pushes its expected outcome to a
// scoreboard queue, due SYNC+DEBOUNCE+2 cycles after the drive (drive just
// after edge n, first sampling edge n+1, pulse visible after edge n+8).
// A negedge monitor pops due entries and compares every output each cycle.
// ----------------------------------------------------------------------------
module tb_quadrature_decoder;
    import quad_pkg::*;

    localparam int SYNC    = 2;
    localparam int DEB     = 4;
    localparam int DUE_OFS = SYNC + DEB + 2;

    logic clk = 1'b0;
    logic reset, enc_a, enc_b, enable, error_clear;
    logic inc4, dec4, dir4, err4;
    logic inc1, dec1, dir1, err1;

    always #5 clk = ~clk;

    quadrature_decoder dut4 (
        .clk (clk), .reset (reset), .enc_a (enc_a), .enc_b (enc_b),
        .enable (enable), .error_clear (error_clear),
        .increment (inc4), .decrement (dec4), .direction (dir4), .error (err4)
    );

    quadrature_decoder #(.SYNC_STAGES (SYNC), .DEBOUNCE_CYCLES (DEB), .RES (1)) dut1 (
        .clk (clk), .reset (reset), .enc_a (enc_a), .enc_b (enc_b),
        .enable (enable), .error_clear (error_clear),
        .increment (inc1), .decrement (dec1), .direction (dir1), .error (err1)
    );

    typedef struct {
        int     due;
        logic   i4, d4, i1, d1;  // pulses if enabled, per instance
        logic   du, dv;          // direction update and value
        logic   es;              // illegal jump: error set if enabled
        logic   cs;              // check FSM state at the due cycle
        phase_t st;
    } sb_t;

    typedef struct {
        logic a, b;
        int   hold;
        logic i4, d4, i1, d1, dv;
    } vec_t;

    sb_t  sb[$];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_errors = 0;
    logic rst_s = 1'b1, en_s = 1'b1, clr_s = 1'b0;
    logic dir_exp = 1'b0, err_exp = 1'b0;

    always @(posedge clk) begin
        cyc   <= cyc + 1;
        rst_s <= reset;
        en_s  <= enable;
        clr_s <= error_clear;
    end

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        logic x_i4, x_d4, x_i1, x_d1;
        sb_t  e;
        x_i4 = 1'b0; x_d4 = 1'b0; x_i1 = 1'b0; x_d1 = 1'b0;
        if (rst_s) begin
            sb.delete();
            dir_exp = 1'b0;
            err_exp = 1'b0;
            chk("reset_state4", int'(dut4.state_q), int'(ST_INIT));
            chk("reset_state1", int'(dut1.state_q), int'(ST_INIT));
        end else begin
            if (sb.size() > 0 && sb[0].due < cyc) begin
                chk("sb_missed_due", sb[0].due, cyc);
                void'(sb.pop_front());
            end
            if (sb.size() > 0 && sb[0].due == cyc) begin
                e = sb.pop_front();
                x_i4 = e.i4 & en_s; x_d4 = e.d4 & en_s;
                x_i1 = e.i1 & en_s; x_d1 = e.d1 & en_s;
                if (e.du) dir_exp = e.dv;
                if (e.es && en_s) err_exp = 1'b1;
                else if (clr_s) err_exp = 1'b0;
                if (e.cs) begin
                    chk("state4", int'(dut4.state_q), int'(e.st));
                    chk("state1", int'(dut1.state_q), int'(e.st));
                end
            end else if (clr_s) begin
                err_exp = 1'b0;
            end
        end
        chk("increment4", int'(inc4), int'(x_i4));
        chk("decrement4", int'(dec4), int'(x_d4));
        chk("direction4", int'(dir4), int'(dir_exp));
        chk("error4",     int'(err4), int'(err_exp));
        chk("increment1", int'(inc1), int'(x_i1));
        chk("decrement1", int'(dec1), int'(x_d1));
        chk("direction1", int'(dir1), int'(dir_exp));
        chk("error1",     int'(err1), int'(err_exp));
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input logic i4, d4, i1, d1, du, dv, es, cs, input phase_t st);
        sb_t e;
        e.due = cyc + DUE_OFS;
        e.i4 = i4; e.d4 = d4; e.i1 = i1; e.d1 = d1;
        e.du = du; e.dv = dv; e.es = es; e.cs = cs; e.st = st;
        sb.push_back(e);
        $display("txn cyc=%0d enc=%b%b due=%0d inc4=%b dec4=%b inc1=%b dec1=%b ill=%b en=%b",
                 cyc, enc_a, enc_b, e.due, i4, d4, i1, d1, es, enable);
    endtask

    // Legal or illegal phase change, held for 'hold' cycles.
    task automatic step(input logic a, b, input int hold,
                        input logic i4, d4, i1, d1, du, dv, es, cs, input phase_t st);
        enc_a = a; enc_b = b;
        push(i4, d4, i1, d1, du, dv, es, cs, st);
        wait_cyc(hold);
    endtask

    task automatic drive_raw(input logic a, b, input int n);
        enc_a = a; enc_b = b;
        wait_cyc(n);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vec [12];
        vec[0]  = '{1'b0, 1'b1, 10, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};  // 00->01 fwd
        vec[1]  = '{1'b1, 1'b1, 10, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};  // 01->11 fwd
        vec[2]  = '{1'b1, 1'b0, 10, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};  // 11->10 fwd
        vec[3]  = '{1'b0, 1'b0, 10, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};  // 10->00 fwd
        for (int k = 0; k < 2; k++) begin
            vec[4+4*k] = '{1'b1, 1'b0, 10, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};  // 00->10 rev
            vec[5+4*k] = '{1'b1, 1'b1, 10, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};  // 10->11 rev
            vec[6+4*k] = '{1'b0, 1'b1, 10, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};  // 11->01 rev
            vec[7+4*k] = '{1'b0, 1'b0, 10, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};  // 01->00 rev
        end

        reset = 1'b1; enc_a = 1'b0; enc_b = 1'b0; enable = 1'b1; error_clear = 1'b0;
        wait_cyc(5);
        reset = 1'b0;
        wait_cyc(20);

        // Forward x4 then two reverse cycles, from the table
        for (int i = 0; i < 12; i++) begin
            step(vec[i].a, vec[i].b, vec[i].hold, vec[i].i4, vec[i].d4,
                 vec[i].i1, vec[i].d1, 1'b1, vec[i].dv, 1'b0, 1'b0, ST_INIT);
        end

        // Glitch rejection: 3-cycle pulse is ignored, 4-cycle pulse passes
        drive_raw(1'b1, 1'b0, 3);
        drive_raw(1'b0, 1'b0, 15);
        step(1'b1, 1'b0, 4,  1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, ST_INIT);
        step(1'b0, 1'b0, 12, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, ST_P00);

        // Enable gating: disabled step is tracked but silent
        enable = 1'b0;
        step(1'b0, 1'b1, 10, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, ST_P01);
        enable = 1'b1;
        step(1'b1, 1'b1, 10, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, ST_P11);
        step(1'b0, 1'b1, 10, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, ST_INIT);
        step(1'b0, 1'b0, 10, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, ST_INIT);

        // Illegal jump 00->11
        step(1'b1, 1'b1, 12, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, ST_P11);
        // Second illegal jump 11->00 landing together with error_clear
        enc_a = 1'b0; enc_b = 1'b0;
        push(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, ST_P00);
        wait_cyc(DUE_OFS - 1);
        error_clear = 1'b1;
        wait_cyc(1);
        error_clear = 1'b0;
        wait_cyc(6);
        // Quiet-cycle clear
        error_clear = 1'b1;
        wait_cyc(1);
        error_clear = 1'b0;
        wait_cyc(4);

        // Reset lands on the edge where an increment is due
        enc_a = 1'b0; enc_b = 1'b1;
        push(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, ST_INIT);
        wait_cyc(DUE_OFS - 1);
        reset = 1'b1;
        wait_cyc(3);
        reset = 1'b0;
        wait_cyc(20);
        step(1'b1, 1'b1, 12, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, ST_P11);

        chk("sb_drained", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
